// File: rtl/border_detection.sv
// Row-parallel 3x3 Sobel edge detector: one full row of edge magnitudes per clock, one-cycle latency.
// Optional binarization is enabled by defining BORDER_THRESHOLD_EN (uses THRESHOLD).
module border_detection #(
    parameter int WIDTH     = 320,
    parameter int THRESHOLD = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in1 [WIDTH],
    input  logic [7:0] in2 [WIDTH],
    input  logic [7:0] in3 [WIDTH],
    output logic [7:0] out [WIDTH]
);

    logic [7:0] out_d [WIDTH];
    logic [7:0] out_q [WIDTH];

    // Gradients are 12-bit two's complement; each weighted sum is at most 1020, so nothing overflows.
    function automatic logic [7:0] sobel_pix(
        input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
        input logic [7:0] m0, input logic [7:0] m2,
        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2
    );
        logic [11:0] gx;
        logic [11:0] gy;
        logic [11:0] ax;
        logic [11:0] ay;
        logic [11:0] mag;
        gx  = (12'(t2) + (12'(m2) << 1) + 12'(b2)) - (12'(t0) + (12'(m0) << 1) + 12'(b0));
        gy  = (12'(b0) + (12'(b1) << 1) + 12'(b2)) - (12'(t0) + (12'(t1) << 1) + 12'(t2));
        ax  = gx[11] ? (12'd0 - gx) : gx;
        ay  = gy[11] ? (12'd0 - gy) : gy;
        mag = ax + ay;
`ifdef BORDER_THRESHOLD_EN
        if (mag >= 12'(THRESHOLD)) begin
            return 8'hFF;
        end else begin
            return 8'h00;
        end
`else
        if (mag > 12'd255) begin
            return 8'hFF;
        end else begin
            return mag[7:0];
        end
`endif
    endfunction

    for (genvar x = 0; x < WIDTH; x++) begin : g_col
        if (x == 0 || x == WIDTH - 1) begin : g_edge
            assign out_d[x] = 8'h00;
        end else begin : g_inner
            assign out_d[x] = sobel_pix(in1[x-1], in1[x], in1[x+1],
                                        in2[x-1],          in2[x+1],
                                        in3[x-1], in3[x], in3[x+1]);
        end
    end

    // Output row register; reset clears the held row without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                out_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_border_detection.sv
// Directed + random streaming bench for border_detection with a queue-based scoreboard.
module tb_border_detection;

    localparam int W = 320;

    logic       clk;
    logic       rst_n;
    logic [7:0] in1_s [W];
    logic [7:0] in2_s [W];
    logic [7:0] in3_s [W];
    logic [7:0] out_s [W];

    int errors = 0;
    int checks = 0;
    logic [W*8-1:0] exp_q [$];

    border_detection #(.WIDTH(W), .THRESHOLD(128)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in1  (in1_s),
        .in2  (in2_s),
        .in3  (in3_s),
        .out  (out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_pix(int x);
        int gx;
        int gy;
        int m;
        if (x == 0 || x == W - 1) return 8'd0;
        gx = int'(in1_s[x+1]) + 2 * int'(in2_s[x+1]) + int'(in3_s[x+1])
           - int'(in1_s[x-1]) - 2 * int'(in2_s[x-1]) - int'(in3_s[x-1]);
        gy = int'(in3_s[x-1]) + 2 * int'(in3_s[x]) + int'(in3_s[x+1])
           - int'(in1_s[x-1]) - 2 * int'(in1_s[x]) - int'(in1_s[x+1]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef BORDER_THRESHOLD_EN
        return (m >= 128) ? 8'd255 : 8'd0;
`else
        return (m > 255) ? 8'd255 : 8'(m);
`endif
    endfunction

    function automatic logic [W*8-1:0] ref_row();
        logic [W*8-1:0] v;
        for (int x = 0; x < W; x++) v[x*8 +: 8] = ref_pix(x);
        return v;
    endfunction

    function automatic logic [W*8-1:0] pack_out();
        logic [W*8-1:0] v;
        for (int x = 0; x < W; x++) v[x*8 +: 8] = out_s[x];
        return v;
    endfunction

    task automatic set_uniform(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int x = 0; x < W; x++) begin
            in1_s[x] = a;
            in2_s[x] = b;
            in3_s[x] = c;
        end
    endtask

    task automatic set_step();
        for (int x = 0; x < W; x++) begin
            in1_s[x] = (x < 160) ? 8'd0 : 8'd255;
            in2_s[x] = in1_s[x];
            in3_s[x] = in1_s[x];
        end
    endtask

    task automatic set_random();
        for (int x = 0; x < W; x++) begin
            in1_s[x] = 8'($urandom_range(0, 255));
            in2_s[x] = 8'($urandom_range(0, 255));
            in3_s[x] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic check_row(input string tag, input logic [W*8-1:0] exp);
        logic [W*8-1:0] got;
        int col;
        got = pack_out();
        col = -1;
        for (int x = W - 1; x >= 0; x--) if (got[x*8 +: 8] !== exp[x*8 +: 8]) col = x;
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: col %0d observed %0d expected %0d", tag, col,
                   got[(col < 0 ? 0 : col)*8 +: 8], exp[(col < 0 ? 0 : col)*8 +: 8]);
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive current rows into the scoreboard, clock once, then compare the popped expectation.
    task automatic step(input string tag);
        logic [W*8-1:0] e;
        exp_q.push_back(ref_row());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_row(tag, e);
        end
    endtask

    initial begin
        logic [W*8-1:0] zero_row;
        logic [7:0] v40;
        logic [7:0] v200;
        zero_row = '0;
        v40 = 8'd40;
`ifdef BORDER_THRESHOLD_EN
        v40  = 8'd0;
        v200 = 8'd255;
`else
        v200 = 8'd200;
`endif
        rst_n = 1'b1;
        set_uniform(8'd0, 8'd0, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_row("reset_async", zero_row);
        set_random();
        repeat (2) @(posedge clk);
        #1;
        check_row("reset_hold", zero_row);
        rst_n = 1'b1;

        set_uniform(8'd100, 8'd100, 8'd100);
        step("uniform");

        set_step();
        step("vstep");
        check_val("vstep_159", out_s[159], 8'd255);
        check_val("vstep_160", out_s[160], 8'd255);
        check_val("vstep_158", out_s[158], 8'd0);

        set_uniform(8'd0, 8'd0, 8'd10);
        step("ramp");
        check_val("ramp_1", out_s[1], v40);
        check_val("ramp_318", out_s[318], v40);
        check_val("ramp_0", out_s[0], 8'd0);
        check_val("ramp_319", out_s[319], 8'd0);

        set_uniform(8'd0, 8'd0, 8'd50);
        step("thresh50");
        check_val("thresh50_5", out_s[5], v200);

        set_step();
        step("vstep_again");
        #2;
        rst_n = 1'b0;
        #1;
        check_row("mid_reset", zero_row);
        set_uniform(8'd0, 8'd0, 8'd10);
        @(posedge clk);
        #1;
        check_row("mid_reset_hold", zero_row);
        rst_n = 1'b1;
        step("post_reset_ramp");
        check_val("post_reset_100", out_s[100], v40);

        for (int c = 0; c < 237; c++) begin
            if (c % 50 == 7) set_step();
            else set_random();
            step("stream");
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
